// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: width helper and FSM state encoding.
package word_serializer_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/word_serializer_lane_mux.sv
// Combinational N_LANES:1 selector picking one LANE_W-bit lane out of a word.
module word_serializer_lane_mux #(
    parameter int LANE_W  = 8,
    parameter int N_LANES = 4,
    parameter int SEL_W   = 2
) (
    input  logic [N_LANES*LANE_W-1:0] word_i,
    input  logic [SEL_W-1:0]          sel_i,
    output logic [LANE_W-1:0]         lane_o
);

    // Explicit compare loop keeps out-of-range selects at zero for non power-of-two lane counts.
    always_comb begin
        lane_o = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (sel_i == SEL_W'(i)) lane_o = word_i[i*LANE_W +: LANE_W];
        end
    end

endmodule

// File: rtl/word_serializer.sv
// Splits a DATA_W word into LANE_W beats on a valid/ready stream, MSB- or LSB-lane first,
// with a per-word lane count and back-to-back word acceptance on the final beat.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int LANE_W  = 8,
    localparam int N_LANES = DATA_W / LANE_W,
    localparam int CNT_W   = clog2(N_LANES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_msb_first,
    input  logic [CNT_W-1:0]  in_count,
    output logic [LANE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_idx,
    output logic              out_last
);

    localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(N_LANES - 1);
    localparam logic [CNT_W:0]   REM_ALL = (CNT_W+1)'(N_LANES);
    localparam logic [CNT_W:0]   REM_ONE = (CNT_W+1)'(1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                msb_q, msb_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W:0]      rem_q, rem_d;
    logic [LANE_W-1:0]   out_data_q, lane_d;

    assign out_valid = (state_q == ST_SEND);
    assign out_last  = out_valid && (rem_q == REM_ONE);
    assign in_ready  = (state_q == ST_IDLE) || (out_last && out_ready);
    assign out_idx   = idx_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        msb_d   = msb_q;
        idx_d   = idx_q;
        rem_d   = rem_q;

        if (state_q == ST_SEND && out_ready) begin
            if (out_last) begin
                state_d = ST_IDLE;
            end else begin
                rem_d = rem_q - 1'b1;
                idx_d = msb_q ? idx_q - 1'b1 : idx_q + 1'b1;
            end
        end

        // A new word overrides the return to IDLE, giving gapless back-to-back words.
        if (in_valid && in_ready) begin
            state_d = ST_SEND;
            word_d  = in_data;
            msb_d   = in_msb_first;
            idx_d   = in_msb_first ? IDX_TOP : '0;
            rem_d   = (in_count == '0) ? REM_ALL : {1'b0, in_count};
        end
    end

    // Lane is selected from next-state word/index so out_data comes straight from a flop.
    word_serializer_lane_mux #(
        .LANE_W  (LANE_W),
        .N_LANES (N_LANES),
        .SEL_W   (CNT_W)
    ) u_lane_mux (
        .word_i (word_d),
        .sel_i  (idx_d),
        .lane_o (lane_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            msb_q      <= 1'b0;
            idx_q      <= '0;
            rem_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            msb_q      <= msb_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            out_data_q <= lane_d;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: driver pushes modelled beats, monitor pops and compares.
module tb_word_serializer;

    localparam int DW = 32;
    localparam int LW = 8;
    localparam int NL = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_msb_first = 1'b0;
    logic [CW-1:0] in_count = '0;
    logic [LW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_idx;
    logic          out_last;

    word_serializer #(.DATA_W(DW), .LANE_W(LW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_msb_first (in_msb_first),
        .in_count     (in_count),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LW-1:0] data;
        logic [CW-1:0] idx;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [LW-1:0] seen[$];
    int            checks = 0;
    int            errors = 0;
    int            nbeats = 0;
    int            rdy_mode = 0;   // 0: always ready, 1: random, 2: pattern 1,0,0,1
    int            pat_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: beat k of a word is lane (msb ? N-1-k : k), last on beat count-1.
    task automatic push_word(input logic [DW-1:0] d, input bit msb, input logic [CW-1:0] cnt);
        int    n;
        int    lane;
        beat_t b;
        n = (cnt == 0) ? NL : int'(cnt);
        for (int k = 0; k < n; k++) begin
            lane   = msb ? (NL - 1 - k) : k;
            b.data = LW'(d >> (lane * LW));
            b.idx  = CW'(lane);
            b.last = (k == n - 1);
            exp_q.push_back(b);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
                out_ready = (pat_cnt % 3) == 0;
                pat_cnt++;
            end
            default: out_ready = 1'b1;
        endcase
    end

    task automatic send_word(input logic [DW-1:0] d, input bit msb, input logic [CW-1:0] cnt);
        bit got;
        @(posedge clk);
        #1;
        in_data      = d;
        in_msb_first = msb;
        in_count     = cnt;
        in_valid     = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (got) push_word(d, msb, cnt);
        else check("accept_timeout", 32'(got), 32'd1);
    endtask

    task automatic idle_in();
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_data      = DW'($urandom);
        in_msb_first = 1'($urandom_range(0, 1));
        in_count     = CW'($urandom_range(0, NL - 1));
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_seen(input string name, input logic [31:0] lanes, input int n);
        logic [31:0] v;
        v = lanes;
        check({name, "_count"}, 32'(seen.size()), 32'(n));
        for (int i = 0; i < n && i < seen.size(); i++)
            check({name, "_data"}, 32'(seen[i]), 32'(v[(n-1-i)*8 +: 8]));
    endtask

    // Monitor: compare accepted beats to the scoreboard, stall stability, in_ready rule.
    logic [LW-1:0] prev_data;
    logic [CW-1:0] prev_idx;
    logic          prev_last;
    bit            prev_stall = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_idx", 32'(out_idx), 32'(prev_idx));
                check("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid) check("in_ready_send", 32'(in_ready), 32'(out_last & out_ready));
            else check("in_ready_idle", 32'(in_ready), 32'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(out_data), 32'(e.data));
                    check("beat_idx", 32'(out_idx), 32'(e.idx));
                    check("beat_last", 32'(out_last), 32'(e.last));
                end
                seen.push_back(out_data);
                nbeats++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
            prev_last  = out_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cnt;
        bit got;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: msb-first full word
        seen.delete();
        send_word(32'h11223344, 1'b1, 2'd0);
        idle_in();
        drain();
        check_seen("t1", 32'h11223344, 4);

        // 2: lsb-first full word
        seen.delete();
        send_word(32'h11223344, 1'b0, 2'd0);
        idle_in();
        drain();
        check_seen("t2", 32'h44332211, 4);

        // 3: partial count
        seen.delete();
        send_word(32'hAABBCCDD, 1'b0, 2'd2);
        idle_in();
        drain();
        check_seen("t3", 32'h0000DDCC, 2);

        // 1-lane word
        seen.delete();
        send_word(32'h5566_7788, 1'b1, 2'd1);
        idle_in();
        drain();
        check_seen("t3b", 32'h00000055, 1);

        // 4: stalls from a 1,0,0 ready pattern
        rdy_mode = 2;
        send_word(32'hCAFEF00D, 1'b1, 2'd0);
        send_word(32'h01234567, 1'b0, 2'd3);
        idle_in();
        drain();
        rdy_mode = 0;

        // 5: two back-to-back words at full rate
        @(posedge clk);
        fork
            begin
                send_word(32'h0A0B0C0D, 1'b1, 2'd0);
                send_word(32'h1A1B1C1D, 1'b0, 2'd0);
                idle_in();
            end
            begin
                got = 1'b0;
                for (int t = 0; t < 100 && !got; t++) begin
                    @(negedge clk);
                    if (out_valid) got = 1'b1;
                end
                cnt = got ? 1 : 0;
                repeat (7) begin
                    @(negedge clk);
                    if (out_valid && out_ready) cnt++;
                end
                check("t5_gapless_beats", 32'(cnt), 32'd8);
                @(negedge clk);
                check("t5_idle_after", 32'(out_valid), 32'd0);
            end
        join
        drain();

        // 6: reset after the second beat
        seen.delete();
        base = nbeats;
        send_word(32'hDEADBEEF, 1'b1, 2'd0);
        idle_in();
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            #1;
            if (nbeats >= base + 2) got = 1'b1;
        end
        check("t6_two_beats", 32'(got), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 exp_q.delete();
        @(negedge clk);
        check("t6_valid_low", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        base = nbeats;
        @(negedge clk);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        repeat (5) @(negedge clk);
        check("t6_no_beats", 32'(nbeats), 32'(base));
        check_seen("t6", 32'h0000DEAD, 2);

        // Randomized words with random backpressure and idle gaps
        rdy_mode = 1;
        repeat (60) begin
            send_word(DW'($urandom), 1'($urandom_range(0, 1)), CW'($urandom_range(0, NL - 1)));
            if ($urandom_range(0, 3) == 0) begin
                idle_in();
                repeat ($urandom_range(0, 4)) @(posedge clk);
            end
        end
        idle_in();
        drain();
        rdy_mode = 0;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
